pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the five-stage Y86-64 pipeline.
- Generates stall/bubble for the F, D, E, M and W pipeline registers, plus set_cc for the condition-code register.
- Sequences a post-reset flush of the unreset pipeline registers, then latches halt/exception status.
- Sits beside the stage registers; all stage-register stall/bubble inputs come from here.

Parameters:
- FLUSH_CYCLES, 4: number of cycles after reset release during which all stages are bubbled.
- CNT_W, 32: width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- D_icode  in  4  icode in the decode register.
- d_srcA  in  4  decode source register A; 0xF means none.
- d_srcB  in  4  decode source register B; 0xF means none.
- E_icode  in  4  icode in the execute register.
- E_dstM  in  4  execute-stage memory destination register.
- e_Cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode in the memory register.
- m_stat  in  3  status out of the memory stage.
- W_stat  in  3  status in the writeback register.
- F_stall  out  1  hold the fetch PC register.
- D_stall  out  1  hold the decode register.
- D_bubble  out  1  load NOP into the decode register.
- E_bubble  out  1  load NOP into the execute register.
- M_bubble  out  1  load NOP into the memory register.
- W_stall  out  1  hold the writeback register.
- W_bubble  out  1  load NOP into the writeback register.
- set_cc  out  1  enable the condition-code update.
- cpu_stat  out  3  latched processor status.
- halted  out  1  processor stopped.

Behaviour:
- Encodings:
  - Status: AOK=1, HLT=2, ADR=3, INS=4.
  - icodes: HALT=0, NOP=1, JXX=7, RET=9, MRMOVQ=5, POPQ=0xB, OPQ=6.
- FSM states: FLUSH, RUN, HALTED. A flush counter of width clog2(FLUSH_CYCLES+1) is used in FLUSH.
- Reset (asynchronous, applied immediately, including mid-operation):
  - state=FLUSH, counter=FLUSH_CYCLES, cpu_stat=AOK, halted=0.
  - Combinational outputs during reset take their FLUSH values.
- FLUSH:
  - Outputs: F_stall=1, D_bubble=E_bubble=M_bubble=W_bubble=1; D_stall=W_stall=set_cc=0.
  - Counter decrements each clock.
  - The cycle the counter reaches 1 is the last FLUSH cycle; the next state is RUN.
- RUN (combinational decode of current inputs):
  - Hazard terms:
    - loaduse = (E_icode==MRMOVQ or POPQ) and E_dstM!=0xF and (E_dstM==d_srcA or E_dstM==d_srcB).
    - mispred = E_icode==JXX and !e_Cnd.
    - ret = RET present in D_icode, E_icode or M_icode.
    - mexc = m_stat!=AOK; wexc = W_stat!=AOK.
  - Outputs:
    - F_stall = loaduse | ret.
    - D_stall = loaduse.
    - D_bubble = mispred | (ret & !loaduse).
    - E_bubble = mispred | loaduse.
    - M_bubble = mexc | wexc.
    - W_stall = wexc.
    - W_bubble = 0.
    - set_cc = E_icode==OPQ & !mexc & !wexc.
  - Simultaneous events:
    - loaduse and ret: stall D, do not bubble D.
    - mispred and ret: bubble D.
    - D_stall and D_bubble are never both 1.
  - Exit: when wexc, register cpu_stat<=W_stat, halted<=1, next state HALTED.
- HALTED:
  - Outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=W_bubble=set_cc=0.
  - cpu_stat and halted hold.
  - Only reset exits this state.
- Latency: stall/bubble outputs are zero-cycle combinational from inputs and state; cpu_stat/halted update one clock after W_stat goes non-AOK.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, three output ports of CNT_W bits are added: cnt_loaduse, cnt_mispred, cnt_ret.
  - Each increments on every RUN cycle in which its hazard term is 1.
  - Counters saturate at all-ones, reset asynchronously to 0, and freeze in FLUSH and HALTED.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset released, all inputs NOP/AOK -> F_stall and all bubbles =1 for exactly 4 clocks; then all outputs 0 and set_cc=0.
- RUN: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same with E_dstM=0xF -> all 0.
- RUN: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1 -> all 0.
- RUN: RET enters D_icode, then E_icode, then M_icode over 3 cycles -> F_stall=1 and D_bubble=1 on each cycle; cleared once no stage holds RET.
- RUN: E_icode=6, m_stat=3 -> set_cc=0, M_bubble=1. Next W_stat=3 -> W_stall=1; one clock later halted=1, cpu_stat=3, and state holds for 10 clocks. Assert rst mid-HALTED -> halted=0, cpu_stat=1 immediately.
- With PIPE_PERF_CNT_EN and CNT_W=4: 20 RUN cycles of mispred -> cnt_mispred=15 (saturated); cnt_loaduse=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/bubble control for the five-stage Y86-64 pipeline.
// After reset it bubbles every stage for FLUSH_CYCLES clocks so that the
// unreset stage registers fill with NOPs. It then decodes load-use,
// mispredicted-branch, return and exception hazards each cycle. When a
// non-AOK status reaches writeback, it latches that status and freezes.
// Optional build macro PIPE_PERF_CNT_EN adds saturating hazard counters
// (cnt_loaduse, cnt_mispred, cnt_ret) of CNT_W bits.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       W_bubble,
  output logic       set_cc,
  output logic [2:0] cpu_stat,
  output logic       halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic [CNT_W-1:0] cnt_ret
`endif
);

  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] flush_cnt;

  logic loaduse, mispred, ret, mexc, wexc;

  // Hazard terms decoded straight from the current stage contents.
  always_comb begin
    loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispred = (E_icode == I_JXX) && !e_Cnd;
    ret     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mexc    = (m_stat != STAT_AOK);
    wexc    = (W_stat != STAT_AOK);
  end

  // State register; reset restarts the flush sequence at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FLUSH;
    else     state <= state_nxt;
  end

  // Next-state decode: flush ends on the cycle the counter shows 1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FLUSH:  if (flush_cnt <= CW'(1)) state_nxt = ST_RUN;
      ST_RUN:    if (wexc) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_FLUSH;
    endcase
  end

  // Flush counter counts down the remaining bubble cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      flush_cnt <= CW'(FLUSH_CYCLES);
    else if (state == ST_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - CW'(1);
  end

  // Latch the faulting writeback status on the way into HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_stat <= STAT_AOK;
      halted   <= 1'b0;
    end else if (state == ST_RUN && wexc) begin
      cpu_stat <= W_stat;
      halted   <= 1'b1;
    end
  end

  // Stage-register control per state; loaduse wins over ret for D so
  // D_stall and D_bubble are never asserted together.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    set_cc   = 1'b0;
    case (state)
      ST_FLUSH: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
      end
      ST_RUN: begin
        F_stall  = loaduse | ret;
        D_stall  = loaduse;
        D_bubble = mispred | (ret & !loaduse);
        E_bubble = mispred | loaduse;
        M_bubble = mexc | wexc;
        W_stall  = wexc;
        set_cc   = (E_icode == I_OPQ) & !mexc & !wexc;
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
      end
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && v != {CNT_W{1'b1}}) sat_inc = v + CNT_W'(1);
    else                           sat_inc = v;
  endfunction

  // Hazard counters advance only while the pipeline is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_loaduse <= '0;
      cnt_mispred <= '0;
      cnt_ret     <= '0;
    end else if (state == ST_RUN) begin
      cnt_loaduse <= sat_inc(cnt_loaduse, loaduse);
      cnt_mispred <= sat_inc(cnt_mispred, mispred);
      cnt_ret     <= sat_inc(cnt_ret, ret);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl. Output bits are
// packed as {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,W_bubble,set_cc}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc;
  logic [2:0] cpu_stat;
  logic       halted;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] cnt_loaduse, cnt_mispred, cnt_ret;
`endif

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [7:0] P_FLUSH  = 8'b1011_1010;
  localparam logic [7:0] P_HALTED = 8'b1101_1100;
  localparam logic [7:0] P_IDLE   = 8'b0000_0000;

`ifdef PIPE_PERF_CNT_EN
  pipe_hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4)) dut (
`else
  pipe_hazard_ctrl #(.FLUSH_CYCLES(4)) dut (
`endif
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .W_bubble(W_bubble), .set_cc(set_cc),
    .cpu_stat(cpu_stat), .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .cnt_loaduse(cnt_loaduse), .cnt_mispred(cnt_mispred), .cnt_ret(cnt_ret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] d_ic, sa, sb, e_ic, dm;
    logic       cnd;
    logic [3:0] m_ic;
    logic [2:0] ms;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] outs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
    M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  initial begin
    //                name            D     sA    sB    E     dstM  cnd   M     mstat exp
    vecs[0]  = '{"idle",          4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 8'b0000_0000};
    vecs[1]  = '{"loaduse_srcA",  4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 8'b1101_0000};
    vecs[2]  = '{"dstM_none",     4'h6, 4'h3, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 3'd1, 8'b0000_0000};
    vecs[3]  = '{"dstM_src_none", 4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 3'd1, 8'b0000_0000};
    vecs[4]  = '{"popq_srcB",     4'h6, 4'h1, 4'h4, 4'hB, 4'h4, 1'b0, 4'h1, 3'd1, 8'b1101_0000};
    vecs[5]  = '{"mrmov_nomatch", 4'h6, 4'h1, 4'h2, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 8'b0000_0000};
    vecs[6]  = '{"mispred",       4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 8'b0011_0000};
    vecs[7]  = '{"jxx_taken",     4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 8'b0000_0000};
    vecs[8]  = '{"ret_D",         4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 8'b1010_0000};
    vecs[9]  = '{"ret_E",         4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h1, 3'd1, 8'b1010_0000};
    vecs[10] = '{"ret_M",         4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 3'd1, 8'b1010_0000};
    vecs[11] = '{"loaduse_ret",   4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 8'b1101_0000};
    vecs[12] = '{"mispred_ret",   4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 8'b1011_0000};
    vecs[13] = '{"opq_setcc",     4'h1, 4'h3, 4'hF, 4'h6, 4'h3, 1'b0, 4'h1, 3'd1, 8'b0000_0001};
    vecs[14] = '{"opq_mexc",      4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd3, 8'b0000_1000};
    vecs[15] = '{"mexc_ins",      4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd4, 8'b0000_1000};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    #1;
    check("reset_outs", outs(), P_FLUSH);
    check("reset_halted", halted, 0);
    check("reset_stat", cpu_stat, 1);
    tick();
    tick();
    rst = 1'b0;

    // Flush lasts exactly four clocks
    for (int i = 0; i < 4; i++) begin
      check($sformatf("flush_%0d", i), outs(), P_FLUSH);
      tick();
    end
    check("run_idle", outs(), P_IDLE);

    // Table-driven RUN decode
    for (int i = 0; i < 16; i++) begin
      D_icode = vecs[i].d_ic; d_srcA = vecs[i].sa; d_srcB = vecs[i].sb;
      E_icode = vecs[i].e_ic; E_dstM = vecs[i].dm; e_Cnd = vecs[i].cnd;
      M_icode = vecs[i].m_ic; m_stat = vecs[i].ms; W_stat = 3'd1;
      #1;
      check(vecs[i].name, outs(), vecs[i].exp);
      check({vecs[i].name, "_nostall_bubble"}, D_stall & D_bubble, 0);
      tick();
    end

    // RET walking D -> E -> M, then gone
    idle_inputs();
    D_icode = 4'h9;
    #1; check("retseq_D", outs(), 8'b1010_0000); tick();
    D_icode = 4'h1; E_icode = 4'h9;
    #1; check("retseq_E", outs(), 8'b1010_0000); tick();
    E_icode = 4'h1; M_icode = 4'h9;
    #1; check("retseq_M", outs(), 8'b1010_0000); tick();
    M_icode = 4'h1;
    #1; check("retseq_clear", outs(), P_IDLE); tick();

    // Exception reaches writeback, then the unit halts
    idle_inputs();
    E_icode = 4'h6; m_stat = 3'd3;
    #1; check("exc_mem", outs(), 8'b0000_1000);
    tick();
    E_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd3;
    #1;
    check("exc_wb", outs(), 8'b0000_1100);
    check("exc_wb_halted", halted, 0);
    check("exc_wb_stat", cpu_stat, 1);
    tick();
    check("halt_halted", halted, 1);
    check("halt_stat", cpu_stat, 3);
    check("halt_outs", outs(), P_HALTED);
    W_stat = 3'd1; E_icode = 4'h6;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halt_hold_%0d", i), {outs(), 1'b0, halted, 1'b0, cpu_stat}, {P_HALTED, 1'b0, 1'b1, 1'b0, 3'd3});
    end

    // Asynchronous reset mid-HALTED takes effect immediately
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("arst_halted", halted, 0);
    check("arst_stat", cpu_stat, 1);
    check("arst_outs", outs(), P_FLUSH);
    tick();
    rst = 1'b0;
    E_icode = 4'h7; e_Cnd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reflush_%0d", i), outs(), P_FLUSH);
      tick();
    end
    check("rerun_mispred", outs(), 8'b0011_0000);

`ifdef PIPE_PERF_CNT_EN
    // Counters stay frozen through flush, then saturate
    check("cnt_mispred_after_flush", cnt_mispred, 0);
    for (int i = 0; i < 20; i++) tick();
    check("cnt_mispred_sat", cnt_mispred, 15);
    check("cnt_loaduse_zero", cnt_loaduse, 0);
    check("cnt_ret_zero", cnt_ret, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
